// File: rtl/hilo_mdu_if.sv
// ---------------------------------------------------------------------------
// hilo_mdu_if
// Command / write-back bundle between the multicycle control unit and the
// HI/LO multiply-divide sequencer.
//
// Signals:
//   start     command strobe from the control unit
//   op        command code (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   a, b      rs / rt operands (dividend / divisor for divides)
//   busy      sequencer is not idle; control unit holds its execute state
//   done      one-cycle pulse in the HI/LO write cycle
//   div_zero  one-cycle pulse with done when a divide had a zero divisor
//   hi_wena, hi_wdata  write port of the HI register
//   lo_wena, lo_wdata  write port of the LO register
//
// Modports:
//   master  control-unit side (drives the command)
//   slave   sequencer side (drives status and the HI/LO write ports)
// ---------------------------------------------------------------------------
interface hilo_mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        hi_wena;
   logic [31:0] hi_wdata;
   logic        lo_wena;
   logic [31:0] lo_wdata;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi_wena, hi_wdata, lo_wena, lo_wdata
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi_wena, hi_wdata, lo_wena, lo_wdata
   );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mdu_ctrl
// Iterative multiply/divide sequencer that owns every write to the HI and LO
// registers. Multiplies run a 32-step LSB-first shift-add on operand
// magnitudes; divides run a 32-step restoring division. A final FIX cycle
// applies sign correction, then a single WRITE cycle pulses the enables.
// MTHI, MTLO and divide-by-zero skip straight to WRITE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    hilo_mdu_if.slave: command in, busy/done/div_zero and HI/LO
//          write ports out (all registered or decoded from the state)
// ---------------------------------------------------------------------------
module hilo_mdu_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   hilo_mdu_if.slave  bus
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      WRITE
   } state_t;

   state_t      state;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        sign_a;
   logic        sign_b;
   logic        is_div;
   logic        is_signed;
   logic [63:0] acc;
   logic [4:0]  step;

   logic        done_q;
   logic        div_zero_q;
   logic        hi_wena_q;
   logic        lo_wena_q;
   logic [31:0] hi_wdata_q;
   logic [31:0] lo_wdata_q;

   // Command decode and operand magnitudes, used only on acceptance.
   // Bit 0 of the arithmetic op codes selects the unsigned variant.
   logic        cmd_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag_in;
   logic [31:0] b_mag_in;

   always_comb begin
      cmd_signed = ~bus.op[0];
      a_neg      = cmd_signed & bus.a[31];
      b_neg      = cmd_signed & bus.b[31];
      a_mag_in   = a_neg ? (32'd0 - bus.a) : bus.a;
      b_mag_in   = b_neg ? (32'd0 - bus.b) : bus.b;
   end

   // One iteration step of each algorithm.
   // Multiply: add the multiplicand into the upper half when the current
   // multiplier LSB is set, then shift the 65-bit {carry, acc} right by one.
   // Divide: the partial remainder lives in acc[32:0]; the dividend shifts
   // out of mag_a MSB-first while quotient bits shift in at its LSB. The
   // 34-bit difference exposes a borrow bit that decides whether to restore.
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic        div_bit;

   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + {1'b0, (mag_b[0] ? mag_a : 32'd0)};
      div_shift = {acc[31:0], mag_a[31]};
      div_diff  = {1'b0, div_shift} - {2'b0, mag_b};
      div_bit   = ~div_diff[33];
   end

   // Sign correction applied in FIX. The remainder takes the dividend's
   // sign; 0x80000000 / -1 naturally wraps back to 0x80000000.
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   always_comb begin
      prod_fix = (is_signed && (sign_a ^ sign_b)) ? (64'd0 - acc) : acc;
      quot_fix = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - mag_a) : mag_a;
      rem_fix  = (is_signed && sign_a) ? (32'd0 - acc[31:0]) : acc[31:0];
   end

   // Main sequencer. Commands are only looked at in IDLE, so a start while
   // busy is simply dropped. Write-port data is left untouched outside the
   // write cycle; consumers qualify it with the enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mag_a      <= 32'd0;
         mag_b      <= 32'd0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         is_div     <= 1'b0;
         is_signed  <= 1'b0;
         acc        <= 64'd0;
         step       <= 5'd0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_wena_q  <= 1'b0;
         lo_wena_q  <= 1'b0;
         hi_wdata_q <= 32'd0;
         lo_wdata_q <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        if (bus.op[1] && (bus.b == 32'd0)) begin
                           hi_wdata_q <= bus.a;
                           lo_wdata_q <= 32'hFFFF_FFFF;
                           hi_wena_q  <= 1'b1;
                           lo_wena_q  <= 1'b1;
                           done_q     <= 1'b1;
                           div_zero_q <= 1'b1;
                           state      <= WRITE;
                        end else begin
                           mag_a     <= a_mag_in;
                           mag_b     <= b_mag_in;
                           sign_a    <= a_neg;
                           sign_b    <= b_neg;
                           is_signed <= cmd_signed;
                           is_div    <= bus.op[1];
                           acc       <= 64'd0;
                           step      <= 5'd0;
                           state     <= RUN;
                        end
                     end
                     OP_MTHI: begin
                        hi_wdata_q <= bus.a;
                        hi_wena_q  <= 1'b1;
                        done_q     <= 1'b1;
                        state      <= WRITE;
                     end
                     OP_MTLO: begin
                        lo_wdata_q <= bus.a;
                        lo_wena_q  <= 1'b1;
                        done_q     <= 1'b1;
                        state      <= WRITE;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            RUN: begin
               if (is_div) begin
                  acc   <= {31'd0, (div_bit ? div_diff[32:0] : div_shift)};
                  mag_a <= {mag_a[30:0], div_bit};
               end else begin
                  acc   <= {mul_sum, acc[31:1]};
                  mag_b <= {1'b0, mag_b[31:1]};
               end
               step <= step + 5'd1;
               if (step == 5'd31) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (is_div) begin
                  hi_wdata_q <= rem_fix;
                  lo_wdata_q <= quot_fix;
               end else begin
                  hi_wdata_q <= prod_fix[63:32];
                  lo_wdata_q <= prod_fix[31:0];
               end
               hi_wena_q <= 1'b1;
               lo_wena_q <= 1'b1;
               done_q    <= 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               hi_wena_q  <= 1'b0;
               lo_wena_q  <= 1'b0;
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi_wena  = hi_wena_q;
   assign bus.lo_wena  = lo_wena_q;
   assign bus.hi_wdata = hi_wdata_q;
   assign bus.lo_wdata = lo_wdata_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mdu_ctrl
// Directed bench for the HI/LO multiply-divide sequencer. Each accepted
// command pushes its hand-computed write-back onto a scoreboard queue; an
// independent monitor pops and compares whenever the DUT shows a write
// cycle, including the cycle number the write must land in.
// ---------------------------------------------------------------------------
module tb_hilo_mdu_ctrl;

   typedef struct {
      logic        hi_en;
      logic        lo_en;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   localparam int LONG_LAT  = 33;
   localparam int SHORT_LAT = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t sb[$];

   hilo_mdu_if bus ();

   hilo_mdu_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // 10-unit clock and a free-running cycle count used for latency checks
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point; every check steps the counters here
   task automatic checkOutput(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
      checks++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Drive one command for a single accepting edge; optionally push the
   // expected write-back with its absolute cycle number
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic push,
                                input logic exp_busy, input exp_t e,
                                input int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (push) begin
         e.cyc = cyc + lat;
         sb.push_back(e);
      end
      checkOutput("busy_after_accept", {63'd0, bus.busy}, {63'd0, exp_busy});
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         checks++;
         $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles", n);
      end
   endtask

   // Monitor: any write activity must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.done || bus.hi_wena || bus.lo_wena || bus.div_zero) begin
         if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_write: cyc %0d hi_wena %0b lo_wena %0b done %0b required no write",
                     cyc, bus.hi_wena, bus.lo_wena, bus.done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("write_cycle", 64'(cyc), 64'(e.cyc));
            checkOutput("done", {63'd0, bus.done}, 64'd1);
            checkOutput("hi_wena", {63'd0, bus.hi_wena}, {63'd0, e.hi_en});
            checkOutput("lo_wena", {63'd0, bus.lo_wena}, {63'd0, e.lo_en});
            checkOutput("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
            if (e.hi_en) checkOutput("hi_wdata", {32'd0, bus.hi_wdata}, {32'd0, e.hi});
            if (e.lo_en) checkOutput("lo_wdata", {32'd0, bus.lo_wdata}, {32'd0, e.lo});
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Directed sequence
   initial begin
      exp_t none;
      none = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 0};
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;

      #12;
      checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("reset_outputs",
                  {bus.done, bus.div_zero, bus.hi_wena, bus.lo_wena, bus.hi_wdata, bus.lo_wdata[27:0]},
                  64'd0);
      checkOutput("reset_lo_top", {60'd0, bus.lo_wdata[31:28]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Signed and unsigned multiplies
      applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0}, LONG_LAT);
      waitIdle();
      applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0}, LONG_LAT);
      waitIdle();
      applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 0}, LONG_LAT);
      waitIdle();

      // Divides, including the most-negative / -1 corner
      applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0}, LONG_LAT);
      waitIdle();
      applyStimulus(3'b011, 32'd100, 32'd7, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'h0000_0002, 32'h0000_000E, 1'b0, 0}, LONG_LAT);
      waitIdle();
      applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 0}, LONG_LAT);
      waitIdle();

      // Divide by zero: immediate write with div_zero
      applyStimulus(3'b011, 32'h0000_1234, 32'd0, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0}, SHORT_LAT);
      waitIdle();

      // Moves to HI / LO; HI data must hold across the MTLO
      applyStimulus(3'b100, 32'hCAFE_BABE, 32'd0, 1'b1, 1'b1,
                    '{1'b1, 1'b0, 32'hCAFE_BABE, 32'd0, 1'b0, 0}, SHORT_LAT);
      waitIdle();
      applyStimulus(3'b101, 32'h0000_0055, 32'd0, 1'b1, 1'b1,
                    '{1'b0, 1'b1, 32'd0, 32'h0000_0055, 1'b0, 0}, SHORT_LAT);
      waitIdle();
      checkOutput("hi_wdata_hold", {32'd0, bus.hi_wdata}, 64'h0000_0000_CAFE_BABE);

      // MTLO presented at E5 of a running MULT must be dropped
      applyStimulus(3'b000, 32'd3, 32'd4, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'd0, 32'd12, 1'b0, 0}, LONG_LAT);
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'b101;
      bus.a     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("busy_during_ignored_start", {63'd0, bus.busy}, 64'd1);
      waitIdle();

      // Invalid op code leaves the block idle
      applyStimulus(3'b110, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, none, 0);
      repeat (3) @(negedge clk);
      checkOutput("invalid_op_idle", {63'd0, bus.busy}, 64'd0);

      // Reset dropped at E10 of a DIVU aborts without any write
      applyStimulus(3'b011, 32'd1000, 32'd3, 1'b0, 1'b1, none, 0);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midop_reset_busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("midop_reset_outputs",
                  {bus.done, bus.div_zero, bus.hi_wena, bus.lo_wena, bus.hi_wdata, bus.lo_wdata[27:0]},
                  64'd0);
      checkOutput("midop_reset_lo_top", {60'd0, bus.lo_wdata[31:28]}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("after_reset_idle", {63'd0, bus.busy}, 64'd0);

      // First command after reset runs at normal latency
      applyStimulus(3'b001, 32'd6, 32'd7, 1'b1, 1'b1,
                    '{1'b1, 1'b1, 32'd0, 32'd42, 1'b0, 0}, LONG_LAT);
      waitIdle();

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
